// File: rtl/pc_next_mux_if.sv
// pc_next_mux_if: next-PC selection bus between branch control, the PC mux and fetch.
//   pc_plus4, branch_target : candidate next addresses (WIDTH bits)
//   sel                     : 1 picks branch_target, otherwise pc_plus4
//   stall                   : 1 freezes the architectural PC
//   pc_next                 : combinational selected address
//   pc                      : registered architectural PC
//   misaligned              : branch-target alignment fault flag
interface pc_next_mux_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;
    logic             sel;
    logic             stall;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc;
    logic             misaligned;

    modport master (
        output pc_plus4, branch_target, sel, stall,
        input  pc_next, pc, misaligned
    );

    modport slave (
        input  pc_plus4, branch_target, sel, stall,
        output pc_next, pc, misaligned
    );
endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: next-PC selector and architectural PC register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, loads RESET_VECTOR into pc
//   bus   : pc_next_mux_if slave (pc_plus4, branch_target, sel, stall in;
//           pc_next, pc, misaligned out)
// Optional macro PC_MUX_ALIGN_CHECK_EN: flags taken targets with nonzero
// low bits on misaligned and blocks the PC update while flagged.
module pc_next_mux #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_next_mux_if.slave  bus
);
    logic load;

    // if/else rather than ?: so an unknown sel falls back to pc_plus4
    always_comb begin
        if (bus.sel == 1'b1)
            bus.pc_next = bus.branch_target;
        else
            bus.pc_next = bus.pc_plus4;
    end

`ifdef PC_MUX_ALIGN_CHECK_EN
    always_comb begin
        if (bus.sel == 1'b1)
            bus.misaligned = bus.branch_target[1:0] != 2'b00;
        else
            bus.misaligned = 1'b0;
    end
    // a misaligned target behaves like a stall
    assign load = !bus.stall && !bus.misaligned;
`else
    assign bus.misaligned = 1'b0;
    assign load = !bus.stall;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.pc <= RESET_VECTOR;
        else if (load)
            bus.pc <= bus.pc_next;
    end
endmodule

// File: tb/tb_pc_next_mux.sv
// tb_pc_next_mux: scoreboard bench for pc_next_mux with directed vectors.
module tb_pc_next_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pc_next_mux_if #(.WIDTH(32)) bus ();

    pc_next_mux #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc_next;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int n_checks = 0;
    int n_fail = 0;

`ifdef PC_MUX_ALIGN_CHECK_EN
    localparam logic        MIS_EXP    = 1'b1;
    localparam logic [31:0] PC_MIS_EXP = 32'h0000_0008;
`else
    localparam logic        MIS_EXP    = 1'b0;
    localparam logic [31:0] PC_MIS_EXP = 32'h0000_0012;
`endif

    task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // monitor: every expectation is checked against the outputs the DUT presents
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "pc_next", bus.pc_next, e.pc_next);
                cmp(e.name, "pc", bus.pc, e.pc);
                cmp(e.name, "misaligned", {31'b0, bus.misaligned}, {31'b0, e.mis});
            end
        end
    end

    task automatic expect_out(input string name, input logic [31:0] pn, input logic [31:0] p, input logic m);
        exp_t e;
        e.name = name;
        e.pc_next = pn;
        e.pc = p;
        e.mis = m;
        q.push_back(e);
        ->chk_ev;
        #1;
    endtask

    // advance n rising edges, then settle away from the active edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.pc_plus4 = 32'h0000_0004;
        bus.branch_target = 32'h0000_0010;
        bus.sel = 1'b0;
        bus.stall = 1'b0;
        step(2);
        expect_out("reset_hold", 32'h4, 32'h0, 1'b0);
        bus.sel = 1'b1;
        #1;
        expect_out("comb_sel1", 32'h10, 32'h0, 1'b0);
        bus.sel = 1'b0;
        #1;
        expect_out("comb_sel0", 32'h4, 32'h0, 1'b0);
        bus.sel = 1'b1;
        rst_n = 1'b1;
        step(1);
        expect_out("first_load", 32'h10, 32'h10, 1'b0);
        bus.stall = 1'b1;
        bus.sel = 1'b0;
        step(3);
        expect_out("stall_hold", 32'h4, 32'h10, 1'b0);
        bus.stall = 1'b0;
        step(1);
        expect_out("stall_release", 32'h4, 32'h4, 1'b0);
        bus.sel = 1'b1;
        step(1);
        expect_out("reload_target", 32'h10, 32'h10, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 32'h10, 32'h0, 1'b0);
        rst_n = 1'b1;
        bus.sel = 1'b0;
        bus.pc_plus4 = 32'hFFFF_FFFC;
        step(1);
        expect_out("max_addr_seq", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        bus.branch_target = 32'hFFFF_FFFC;
        bus.pc_plus4 = 32'h0000_0004;
        bus.sel = 1'b1;
        #1;
        expect_out("max_addr_tgt", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        bus.stall = 1'b1;
        rst_n = 1'b0;
        #1;
        expect_out("reset_in_stall", 32'hFFFF_FFFC, 32'h0, 1'b0);
        step(1);
        expect_out("reset_held_edge", 32'hFFFF_FFFC, 32'h0, 1'b0);
        rst_n = 1'b1;
        step(1);
        expect_out("release_stalled", 32'hFFFF_FFFC, 32'h0, 1'b0);
        bus.stall = 1'b0;
        bus.sel = 1'b0;
        bus.pc_plus4 = 32'h0000_0008;
        step(1);
        expect_out("load_after_rel", 32'h8, 32'h8, 1'b0);
        bus.stall = 1'b1;
        bus.sel = 1'b1;
        bus.branch_target = 32'h0000_0020;
        step(1);
        expect_out("stall_sel_same", 32'h20, 32'h8, 1'b0);
        bus.stall = 1'b0;
        bus.branch_target = 32'h0000_0012;
        #1;
        expect_out("misaligned_flag", 32'h12, 32'h8, MIS_EXP);
        step(1);
        expect_out("misaligned_edge", 32'h12, PC_MIS_EXP, MIS_EXP);
        bus.sel = 1'b0;
        bus.pc_plus4 = 32'h0000_0040;
        #1;
        expect_out("unsel_target", 32'h40, PC_MIS_EXP, 1'b0);
        step(1);
        expect_out("final_load", 32'h40, 32'h40, 1'b0);
        #5;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_next_mux.md
# pc_next_mux

Next-program-counter selector and PC register for the single-cycle RISC-V core. Each cycle it chooses the sequential address (`pc_plus4`) or the taken branch/jump target (`branch_target`) from a one-bit select driven by branch/jump control. It presents the choice combinationally on `pc_next` and latches it into the architectural PC on the rising clock edge. It sits between the branch-decision logic and the instruction-fetch address port.

## Interface
Parameters:
- `WIDTH`, 32: address width in bits.
- `RESET_VECTOR`, 32'h0000_0000: value loaded into `pc` during reset.

Ports:
- `clk`  in  1: single system clock, rising-edge active.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `pc_plus4`  in  WIDTH: sequential next address (current PC + 4), computed externally.
- `branch_target`  in  WIDTH: taken branch/jump destination.
- `sel`  in  1: 0 selects `pc_plus4`; 1 selects `branch_target`.
- `stall`  in  1: 1 holds `pc` at its current value.
- `pc_next`  out  WIDTH: selected next address, combinational.
- `pc`  out  WIDTH: registered architectural PC.
- `misaligned`  out  1: target-alignment fault flag. Tied to 0 unless `PC_MUX_ALIGN_CHECK_EN` is defined.

## Operation
- `pc_next` = `sel` ? `branch_target` : `pc_plus4`. This path is purely combinational and holds no state.
- `sel` values other than 1 (X or Z in simulation) select `pc_plus4`.
- `pc_next` follows its inputs at all times, including while `rst_n` is low and while `stall` = 1.
- `pc` register update rules:
  - `rst_n` low: `pc` = `RESET_VECTOR`, applied immediately without waiting for a clock edge.
  - Rising `clk` with `rst_n` high and `stall` = 0: `pc` <= `pc_next`. With the alignment check enabled, this update also requires `misaligned` = 0.
  - Rising `clk` with `stall` = 1: `pc` holds its value.
- No arithmetic in this block. Widths pass through unchanged and nothing wraps or truncates. An input of 32'hFFFF_FFFC passes through unchanged.
- `stall` and `sel` may change together. Only the values sampled at the clock edge matter.

## Timing
- `pc_next`: zero-cycle latency; it is a combinational function of `sel`, `pc_plus4` and `branch_target`.
- `pc`: one-cycle latency. It reflects the `pc_next` value sampled at the previous rising edge.
- Reset:
  - Assertion sets `pc` to `RESET_VECTOR` asynchronously, including when reset arrives mid-cycle or during a stall.
  - On deassertion, `pc` stays at `RESET_VECTOR` until the first rising edge with `rst_n` high, which loads `pc_next`. Deassertion is synchronised externally.
- Reset values of outputs:
  - `pc` = `RESET_VECTOR`.
  - `misaligned` = combinational from the inputs (0 when the check is compiled out).
  - `pc_next` = combinational from the inputs.

## Configuration
- Macro: `PC_MUX_ALIGN_CHECK_EN`.
- Defined:
  - `misaligned` = (`sel` == 1) && (`branch_target[1:0]` != 2'b00), combinational.
  - While `misaligned` = 1, `pc` does not update at the clock edge; it behaves as a stall.
  - `pc_next` still shows the raw selected value.
- Undefined:
  - `misaligned` is constant 0.
  - `pc` loads any selected value, aligned or not.

## Test plan
- `pc_plus4`=0x0000_0004, `branch_target`=0x0000_0010, `sel`=0 -> `pc_next`=0x0000_0004 within the same timestep.
- Same inputs, `sel`=1 -> `pc_next`=0x0000_0010. Toggling `sel` back to 0 -> 0x0000_0004, with no clock required.
- Hold `rst_n`=0 with `RESET_VECTOR`=0 while clocking -> `pc`=0x0000_0000. Release, `sel`=1, one rising edge -> `pc`=0x0000_0010.
- `stall`=1, `sel`=0, three edges -> `pc` remains 0x0000_0010. Drop `stall`, one edge -> `pc`=0x0000_0004.
- With `pc`=0x0000_0010, assert `rst_n`=0 mid-cycle, no clock edge -> `pc`=0x0000_0000 immediately.
- `PC_MUX_ALIGN_CHECK_EN` defined, `sel`=1, `branch_target`=0x0000_0012 -> `misaligned`=1 and `pc` unchanged across an edge. With the macro undefined, the same stimulus gives `misaligned`=0 and `pc`=0x0000_0012.
